// File: rtl/full_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_if
// Description : Operand/result bundle for the full_adder cell. The master
//               side drives a, b and ci and receives s and co. The slave side
//               (the adder) does the reverse.
// Revision    : 1.0 - initial release
// ============================================================================
interface full_adder_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic [WIDTH-1:0] s;
    logic             co;

    modport master (
        output a,
        output b,
        output ci,
        input  s,
        input  co
    );

    modport slave (
        input  a,
        input  b,
        input  ci,
        output s,
        output co
    );
endinterface
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : WIDTH-bit ripple-carry full adder. The result {co,s} is the
//               unsigned sum a+b+ci. With OUT_REG=1 the result is registered
//               (1-cycle latency, asynchronous active-high reset). With
//               OUT_REG=0 the result is purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder #(
    parameter int WIDTH   = 1,
    parameter bit OUT_REG = 1'b1
) (
    input  wire               clk,
    input  wire               rst,
    full_adder_if.slave       bus
);

    logic [WIDTH-1:0] w_s;
    logic             w_co;
    logic             w_carry;

    // Ripple carry chain: each bit is a classic sum/majority full-adder cell.
    always_comb begin
        w_carry = bus.ci;
        w_s     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_s[i]  = bus.a[i] ^ bus.b[i] ^ w_carry;
            w_carry = (bus.a[i] & bus.b[i]) |
                      (bus.a[i] & w_carry)  |
                      (bus.b[i] & w_carry);
        end
        w_co = w_carry;
    end

    generate
        if (OUT_REG) begin : g_reg
            logic [WIDTH-1:0] r_s;
            logic             r_co;

            // Result register. Reset clears it at once, which also drops any in-flight sum.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s  <= '0;
                    r_co <= 1'b0;
                end else begin
                    r_s  <= w_s;
                    r_co <= w_co;
                end
            end

            assign bus.s  = r_s;
            assign bus.co = r_co;
        end else begin : g_comb
            // clk and rst have no function when the result is combinational.
            wire w_unused_clk_rst = clk | rst;

            assign bus.s  = w_s;
            assign bus.co = w_co;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_full_adder
// Description : Self-checking bench for full_adder. It covers the registered
//               WIDTH=1, 4 and 8 cells and a combinational WIDTH=1 cell. The
//               reference is plain unsigned addition.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_full_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    full_adder_if #(.WIDTH(1)) if1 ();
    full_adder_if #(.WIDTH(4)) if4 ();
    full_adder_if #(.WIDTH(8)) if8 ();
    full_adder_if #(.WIDTH(1)) ifc ();

    full_adder #(.WIDTH(1), .OUT_REG(1'b1)) u_w1 (.clk(clk), .rst(rst), .bus(if1.slave));
    full_adder #(.WIDTH(4), .OUT_REG(1'b1)) u_w4 (.clk(clk), .rst(rst), .bus(if4.slave));
    full_adder #(.WIDTH(8), .OUT_REG(1'b1)) u_w8 (.clk(clk), .rst(rst), .bus(if8.slave));
    full_adder #(.WIDTH(1), .OUT_REG(1'b0)) u_wc (.clk(clk), .rst(rst), .bus(ifc.slave));

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the unsigned sum, carried out to one bit beyond the operands.
    function automatic logic [64:0] ref_sum(input logic [63:0] a, input logic [63:0] b,
                                            input logic ci);
        return 65'(a) + 65'(b) + 65'(ci);
    endfunction

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got {co,s}=%0h expected %0h", tag, got, exp);
        end
    endtask

    logic [64:0] exp_prev;
    logic [2:0]  v3;
    logic [7:0]  ra, rb;
    logic        rci;

    initial begin
        if1.a = '0; if1.b = '0; if1.ci = 1'b0;
        if4.a = '0; if4.b = '0; if4.ci = 1'b0;
        if8.a = '0; if8.b = '0; if8.ci = 1'b0;
        ifc.a = '0; ifc.b = '0; ifc.ci = 1'b0;

        // Reset state, and outputs held at zero across an edge while in reset.
        @(negedge clk);
        chk("rst_w1", 65'({if1.co, if1.s}), 65'd0);
        chk("rst_w4", 65'({if4.co, if4.s}), 65'd0);
        chk("rst_w8", 65'({if8.co, if8.s}), 65'd0);
        if1.a = 1'b1; if1.b = 1'b1; if1.ci = 1'b1;
        @(negedge clk);
        chk("rst_hold", 65'({if1.co, if1.s}), 65'd0);

        // Exhaustive WIDTH=1 on the registered cell and the combinational cell.
        rst = 1'b0;
        for (int v = 0; v < 8; v++) begin
            v3 = 3'(v);
            if1.ci = v3[2]; if1.a = v3[1]; if1.b = v3[0];
            ifc.ci = v3[2]; ifc.a = v3[1]; ifc.b = v3[0];
            #1;
            chk("comb_exh", 65'({ifc.co, ifc.s}), ref_sum(64'(v3[1]), 64'(v3[0]), v3[2]));
            @(negedge clk);
            chk("reg_exh", 65'({if1.co, if1.s}), ref_sum(64'(v3[1]), 64'(v3[0]), v3[2]));
        end

        // Latency: inputs 000, 111, 011. Outputs must not change before the edge.
        exp_prev = ref_sum(64'(if1.a), 64'(if1.b), if1.ci);
        for (int k = 0; k < 3; k++) begin
            v3 = (k == 0) ? 3'b000 : ((k == 1) ? 3'b111 : 3'b011);
            if1.ci = v3[2]; if1.a = v3[1]; if1.b = v3[0];
            #1;
            chk("lat_pre", 65'({if1.co, if1.s}), exp_prev);
            exp_prev = ref_sum(64'(v3[1]), 64'(v3[0]), v3[2]);
            @(negedge clk);
            chk("lat_post", 65'({if1.co, if1.s}), exp_prev);
        end

        // WIDTH=4 directed cases.
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       begin if4.a = 4'hF; if4.b = 4'h1; if4.ci = 1'b0; end
                1:       begin if4.a = 4'h7; if4.b = 4'h8; if4.ci = 1'b1; end
                default: begin if4.a = 4'h5; if4.b = 4'h2; if4.ci = 1'b0; end
            endcase
            @(negedge clk);
            chk("w4", 65'({if4.co, if4.s}), ref_sum(64'(if4.a), 64'(if4.b), if4.ci));
        end

        // Maximum case on WIDTH=8: all-ones + all-ones + 1.
        if8.a = 8'hFF; if8.b = 8'hFF; if8.ci = 1'b1;
        @(negedge clk);
        chk("w8_max", 65'({if8.co, if8.s}), 65'h1FF);

        // Asynchronous reset between edges, then recovery one edge after release.
        if1.a = 1'b1; if1.b = 1'b1; if1.ci = 1'b1;
        @(negedge clk);
        chk("pre_arst", 65'({if1.co, if1.s}), 65'd3);
        #2 rst = 1'b1;
        #1;
        chk("arst_now", 65'({if1.co, if1.s}), 65'd0);
        chk("arst_w8", 65'({if8.co, if8.s}), 65'd0);
        // The combinational cell must ignore rst.
        ifc.a = 1'b1; ifc.b = 1'b1; ifc.ci = 1'b0;
        #1;
        chk("comb_rst", 65'({ifc.co, ifc.s}), 65'd2);
        @(negedge clk);
        chk("arst_hold", 65'({if1.co, if1.s}), 65'd0);
        rst = 1'b0;
        #1;
        chk("arst_rel", 65'({if1.co, if1.s}), 65'd0);
        @(negedge clk);
        chk("arst_rec", 65'({if1.co, if1.s}), 65'd3);

        // Random WIDTH=8: each result must appear exactly one edge after its inputs.
        exp_prev = ref_sum(64'(if8.a), 64'(if8.b), if8.ci);
        for (int n = 0; n < 1000; n++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rci = 1'($urandom);
            if8.a = ra; if8.b = rb; if8.ci = rci;
            #1;
            chk("rnd_pre", 65'({if8.co, if8.s}), exp_prev);
            exp_prev = ref_sum(64'(ra), 64'(rb), rci);
            @(negedge clk);
            chk("rnd_post", 65'({if8.co, if8.s}), exp_prev);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
